// File: rtl/popcount_scheduler.sv
// Round-robin scheduler sharing one 16-bit popcount tree among NUM_REQ requesters,
// with a registered valid/ready result port and per-requester saturating accumulators.

module adder_tree_16 (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [15:0] bits,
    output logic [4:0]  sum
);
    logic [1:0] l1_s [8];
    logic [2:0] l2_s [4];
    logic [3:0] l3_s [2];
    logic       unused_tie_s;

    // Purely combinational; clock and reset are wired only to keep a uniform port shape.
    assign unused_tie_s = CLK ^ nRST;

    // Balanced binary adder tree, widening by one bit per level.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            l1_s[i] = {1'b0, bits[2*i]} + {1'b0, bits[2*i+1]};
        end
        for (int i = 0; i < 4; i++) begin
            l2_s[i] = {1'b0, l1_s[2*i]} + {1'b0, l1_s[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            l3_s[i] = {1'b0, l2_s[2*i]} + {1'b0, l2_s[2*i+1]};
        end
        sum = {1'b0, l3_s[0]} + {1'b0, l3_s[1]};
    end
endmodule

module popcount_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int ID_WIDTH  = 2,
    parameter int ACC_WIDTH = 16
) (
    input  logic                         CLK,
    input  logic                         nRST,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [16*NUM_REQ-1:0]        req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ-1:0]           acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ID_WIDTH-1:0]          out_id,
    output logic [4:0]                   out_sum,
    output logic [ACC_WIDTH*NUM_REQ-1:0] acc_out
);
    logic [ID_WIDTH-1:0]  ptr_r;
    logic                 out_valid_r;
    logic [ID_WIDTH-1:0]  out_id_r;
    logic [4:0]           out_sum_r;
    logic [ACC_WIDTH-1:0] acc_r     [NUM_REQ];
    logic [ACC_WIDTH-1:0] acc_nxt_s [NUM_REQ];

    logic                 stall_s;
    logic                 found_s;
    logic [NUM_REQ-1:0]   grant_s;
    logic [ID_WIDTH-1:0]  grant_id_s;
    logic                 fire_s;
    logic [15:0]          sel_data_s;
    logic [4:0]           pop_s;
    logic [ACC_WIDTH-1:0] base_s;
    logic [ACC_WIDTH:0]   sum_ext_s;

    assign stall_s = out_valid_r && !out_ready;

    // Rotating-priority search starting just after the last granted requester.
    always_comb begin
        grant_s    = {NUM_REQ{1'b0}};
        grant_id_s = {ID_WIDTH{1'b0}};
        found_s    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found_s && !stall_s && req_valid[i] &&
                    (i == ((int'(ptr_r) + k) % NUM_REQ))) begin
                    grant_s[i] = 1'b1;
                    grant_id_s = ID_WIDTH'(i);
                    found_s    = 1'b1;
                end else begin
                    found_s = found_s;
                end
            end
        end
    end

    // Grant is forced low while reset is held so no transfer is advertised.
    assign req_ready = nRST ? grant_s : {NUM_REQ{1'b0}};
    assign fire_s    = |req_ready;

    // One-hot AND-OR mux feeding the single shared tree.
    always_comb begin
        sel_data_s = 16'h0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s[i]) begin
                sel_data_s = sel_data_s | req_data[16*i +: 16];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    adder_tree_16 u_tree (
        .CLK  (CLK),
        .nRST (nRST),
        .bits (sel_data_s),
        .sum  (pop_s)
    );

    // Next accumulator values: a clear coinciding with a fire keeps only the new sample.
    always_comb begin
        base_s    = {ACC_WIDTH{1'b0}};
        sum_ext_s = {(ACC_WIDTH+1){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            base_s    = acc_clr[i] ? {ACC_WIDTH{1'b0}} : acc_r[i];
            sum_ext_s = {1'b0, base_s} + {{(ACC_WIDTH-4){1'b0}}, pop_s};
            if (req_ready[i]) begin
                acc_nxt_s[i] = sum_ext_s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}}
                                                    : sum_ext_s[ACC_WIDTH-1:0];
            end else if (acc_clr[i]) begin
                acc_nxt_s[i] = {ACC_WIDTH{1'b0}};
            end else begin
                acc_nxt_s[i] = acc_r[i];
            end
        end
    end

    // Result register, round-robin pointer and accumulator state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ptr_r       <= ID_WIDTH'(NUM_REQ - 1);
            out_valid_r <= 1'b0;
            out_id_r    <= {ID_WIDTH{1'b0}};
            out_sum_r   <= 5'd0;
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_r[i] <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            if (fire_s) begin
                out_valid_r <= 1'b1;
                out_id_r    <= grant_id_s;
                out_sum_r   <= pop_s;
                ptr_r       <= grant_id_s;
            end else if (!stall_s) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                acc_r[i] <= acc_nxt_s[i];
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_id    = out_id_r;
    assign out_sum   = out_sum_r;

    // Flatten the accumulator array onto the output bus.
    always_comb begin
        acc_out = {(ACC_WIDTH*NUM_REQ){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            acc_out[i*ACC_WIDTH +: ACC_WIDTH] = acc_r[i];
        end
    end
endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed bench for popcount_scheduler: vector table for arbitration plus
// hand sequences for backpressure, clear collisions, saturation and async reset.

module tb_popcount_scheduler;
    logic        CLK;
    logic        nRST;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [4:0]  out_sum;
    logic [63:0] acc_out;

    logic [3:0]  s_valid;
    logic [63:0] s_data;
    logic [3:0]  s_ready;
    logic [3:0]  s_clr;
    logic        s_ov;
    logic        s_ordy;
    logic [1:0]  s_id;
    logic [4:0]  s_sum;
    logic [19:0] s_acc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  valid;
        logic [63:0] data;
        logic        ordy;
        logic [3:0]  exp_ready;
        logic        exp_ov;
        logic [1:0]  exp_id;
        logic [4:0]  exp_sum;
    } vec_t;

    vec_t tbl [11];

    popcount_scheduler dut (
        .CLK(CLK), .nRST(nRST), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .acc_clr(acc_clr), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id), .out_sum(out_sum), .acc_out(acc_out)
    );

    popcount_scheduler #(.NUM_REQ(4), .ID_WIDTH(2), .ACC_WIDTH(5)) dut_sat (
        .CLK(CLK), .nRST(nRST), .req_valid(s_valid), .req_data(s_data),
        .req_ready(s_ready), .acc_clr(s_clr), .out_valid(s_ov),
        .out_ready(s_ordy), .out_id(s_id), .out_sum(s_sum), .acc_out(s_acc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST      = 1'b0;
        req_valid = 4'b0000;
        req_data  = 64'h0;
        acc_clr   = 4'b0000;
        out_ready = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
    endtask

    task automatic chk_acc(input string nm, input logic [15:0] a0, input logic [15:0] a1,
                           input logic [15:0] a2, input logic [15:0] a3);
        chk({nm, "_acc"}, acc_out, {a3, a2, a1, a0});
    endtask

    initial begin
        s_valid = 4'b0000;
        s_data  = 64'h0;
        s_clr   = 4'b0000;
        s_ordy  = 1'b1;

        for (int r = 0; r < 8; r++) begin
            tbl[r].valid     = 4'b1111;
            tbl[r].data      = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
            tbl[r].ordy      = 1'b1;
            tbl[r].exp_ready = 4'b0001 << (r % 4);
            tbl[r].exp_ov    = 1'b1;
            tbl[r].exp_id    = 2'(r % 4);
            tbl[r].exp_sum   = 5'((r % 4) + 1);
        end
        tbl[8]  = '{4'b1010, {16'h000F, 16'h0007, 16'h0003, 16'h0001}, 1'b1, 4'b0010, 1'b1, 2'd1, 5'd2};
        tbl[9]  = '{4'b1010, {16'h000F, 16'h0007, 16'h0003, 16'h0001}, 1'b1, 4'b1000, 1'b1, 2'd3, 5'd4};
        tbl[10] = '{4'b0001, {16'h000F, 16'h0007, 16'h0003, 16'h0001}, 1'b1, 4'b0001, 1'b1, 2'd0, 5'd1};

        // Reset state, with requests already pending
        nRST      = 1'b0;
        req_valid = 4'b1111;
        req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        acc_clr   = 4'b0000;
        out_ready = 1'b1;
        #7;
        chk("reset_ready", req_ready, 4'b0000);
        chk("reset_ov", out_valid, 1'b0);
        chk("reset_id", out_id, 2'd0);
        chk("reset_sum", out_sum, 5'd0);
        chk_acc("reset", 16'd0, 16'd0, 16'd0, 16'd0);
        do_reset();

        // Single requester
        req_valid = 4'b0001;
        req_data  = {48'h0, 16'hFFFF};
        #1;
        chk("single_ready", req_ready, 4'b0001);
        step();
        chk("single_ov", out_valid, 1'b1);
        chk("single_id", out_id, 2'd0);
        chk("single_sum", out_sum, 5'd16);
        chk_acc("single", 16'd16, 16'd0, 16'd0, 16'd0);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready", req_ready, 4'b0000);
        step();
        chk("idle_ov", out_valid, 1'b0);

        // Round-robin table
        do_reset();
        for (int r = 0; r < 11; r++) begin
            req_valid = tbl[r].valid;
            req_data  = tbl[r].data;
            out_ready = tbl[r].ordy;
            #1;
            chk($sformatf("rr%0d_ready", r), req_ready, tbl[r].exp_ready);
            step();
            chk($sformatf("rr%0d_ov", r), out_valid, tbl[r].exp_ov);
            if (tbl[r].exp_ov) begin
                chk($sformatf("rr%0d_id", r), out_id, tbl[r].exp_id);
                chk($sformatf("rr%0d_sum", r), out_sum, tbl[r].exp_sum);
            end
            if (r == 7) chk_acc("rr_fair", 16'd2, 16'd4, 16'd6, 16'd8);
        end
        chk_acc("rr_end", 16'd3, 16'd6, 16'd6, 16'd12);

        // Backpressure: result of 7 held for three stalled cycles
        req_valid = 4'b0100;
        req_data  = {16'h000F, 16'h007F, 16'h0003, 16'h0001};
        #1;
        chk("bp_first_ready", req_ready, 4'b0100);
        step();
        chk("bp_first_sum", out_sum, 5'd7);
        out_ready = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), req_ready, 4'b0000);
            step();
            chk($sformatf("bp%0d_ov", c), out_valid, 1'b1);
            chk($sformatf("bp%0d_id", c), out_id, 2'd2);
            chk($sformatf("bp%0d_sum", c), out_sum, 5'd7);
            chk_acc($sformatf("bp%0d", c), 16'd3, 16'd6, 16'd13, 16'd12);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", req_ready, 4'b1000);
        step();
        chk("bp_resume_id", out_id, 2'd3);
        chk("bp_resume_sum", out_sum, 5'd4);
        step();
        chk("bp_resume2_ov", out_valid, 1'b1);
        chk("bp_resume2_id", out_id, 2'd0);
        chk("bp_resume2_sum", out_sum, 5'd1);

        // Clear collisions
        do_reset();
        req_valid = 4'b0010;
        req_data  = {16'h0003, 16'h0000, 16'hFFFF, 16'h0000};
        step();
        req_data  = {16'h0003, 16'h0000, 16'h000F, 16'h0000};
        step();
        req_valid = 4'b1000;
        step();
        chk_acc("clr_pre", 16'd0, 16'd20, 16'd0, 16'd2);
        req_valid = 4'b0010;
        req_data  = {16'h0003, 16'h0000, 16'h00FF, 16'h0000};
        acc_clr   = 4'b1010;
        step();
        chk_acc("clr_collide", 16'd0, 16'd8, 16'd0, 16'd0);
        req_valid = 4'b1000;
        acc_clr   = 4'b0000;
        step();
        chk_acc("clr_refill", 16'd0, 16'd8, 16'd0, 16'd2);
        req_valid = 4'b0000;
        acc_clr   = 4'b1000;
        step();
        chk_acc("clr_only3", 16'd0, 16'd8, 16'd0, 16'd0);
        acc_clr   = 4'b0000;

        // Async reset mid-stream
        do_reset();
        req_valid = 4'b0001;
        req_data  = {48'h0, 16'hFFFF};
        step();
        step();
        req_data  = {48'h0, 16'h00FF};
        step();
        chk("ar_pre_ov", out_valid, 1'b1);
        chk_acc("ar_pre", 16'd40, 16'd0, 16'd0, 16'd0);
        req_valid = 4'b1111;
        req_data  = 64'h0001_0001_0001_0001;
        #3;
        nRST = 1'b0;
        #1;
        chk("ar_ov", out_valid, 1'b0);
        chk("ar_ready", req_ready, 4'b0000);
        chk_acc("ar", 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        chk("ar_release_ready", req_ready, 4'b0001);
        step();
        chk("ar_release_id", out_id, 2'd0);

        // Saturation on the 5-bit accumulator instance
        req_valid = 4'b0000;
        s_valid   = 4'b0100;
        s_data    = {16'h0000, 16'hFFFF, 32'h0};
        step();
        chk("sat1", s_acc, {5'd0, 5'd16, 5'd0, 5'd0});
        step();
        chk("sat2", s_acc, {5'd0, 5'd31, 5'd0, 5'd0});
        step();
        chk("sat3", s_acc, {5'd0, 5'd31, 5'd0, 5'd0});
        chk("sat_sum", s_sum, 5'd16);
        s_valid = 4'b0000;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
